// File: rtl/instr_mem.sv
// Synchronous instruction memory for the MIPS IF stage: registered fetch with stall
// hold and out-of-range flagging, plus a byte-serial program loader.
module instr_mem #(
  parameter int          ADDR_BITS    = 7,
  parameter logic [31:0] DEFAULT_WORD = 32'h8000_0000,
  parameter              INIT_FILE    = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic [31:0]          addr,
  output logic [31:0]          data,
  output logic                 data_valid,
  output logic                 oob,
  input  logic                 ld_start,
  input  logic [ADDR_BITS:0]   ld_len,
  input  logic                 ld_byte_valid,
  input  logic [7:0]           ld_byte,
  output logic                 ld_busy,
  output logic                 ld_done,
  output logic [ADDR_BITS:0]   ld_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t               r_state, w_state_next;
  logic [31:0]          r_mem [0:DEPTH-1];
  logic [23:0]          r_asm;
  logic [1:0]           r_byte_cnt;
  logic [ADDR_BITS:0]   r_len;
  logic [ADDR_BITS:0]   r_count;
  logic [31:0]          r_data;
  logic                 r_data_valid;
  logic                 r_oob;

  logic [ADDR_BITS:0]   w_len_clamped;
  logic                 w_byte_take;
  logic                 w_word_done;
  logic [31:0]          w_word;
  logic                 w_oob;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_fetch_block;

  assign w_len_clamped = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
  // A start (in any state) takes priority over the byte presented with it.
  assign w_byte_take   = (r_state == ST_LOAD) && !ld_start && ld_byte_valid;
  assign w_word_done   = w_byte_take && (r_byte_cnt == 2'd3);
  assign w_word        = {r_asm, ld_byte};
  assign w_oob         = |addr[30:ADDR_BITS+2];
  assign w_idx         = addr[ADDR_BITS+1:2];
  assign w_fetch_block = ld_busy || ld_start;

  always_comb begin
    w_state_next = r_state;
    if (ld_start) begin
      w_state_next = (w_len_clamped == '0) ? ST_DONE : ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (w_word_done && (r_count == r_len - 1'b1)) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (ld_start) begin
        r_byte_cnt <= '0;
        r_count    <= '0;
        r_len      <= w_len_clamped;
      end else if (w_byte_take) begin
        r_asm      <= {r_asm[15:0], ld_byte};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_word_done) r_count <= r_count + 1'b1;
      end
    end
  end

  // Memory array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && w_word_done) r_mem[r_count[ADDR_BITS-1:0]] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (reset || w_fetch_block) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_oob        <= 1'b0;
    end else if (fetch_en) begin
      r_data       <= w_oob ? DEFAULT_WORD : r_mem[w_idx];
      r_data_valid <= 1'b1;
      r_oob        <= w_oob;
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign oob        = r_oob;
  assign ld_busy    = (r_state != ST_IDLE);
  assign ld_done    = (r_state == ST_DONE);
  assign ld_count   = r_count;

endmodule
